// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write port and scoreboard signals of regfile_wb_arbiter.
// master = requesters/issue logic side, slave = the arbiter.
interface regfile_wb_arbiter_if;
   logic        iA_VALID;
   logic [4:0]  iA_RD;
   logic [31:0] iA_DATA;
   logic        oA_READY;
   logic        iB_VALID;
   logic [4:0]  iB_RD;
   logic [31:0] iB_DATA;
   logic        oB_READY;
   logic        oWE;
   logic [4:0]  oRD;
   logic [31:0] oWDATA;
   logic        iISSUE;
   logic [4:0]  iISSUE_RD;
   logic [4:0]  iRS1;
   logic [4:0]  iRS2;
   logic        oHAZARD;
   logic [31:0] oBUSY;

   modport master (
      output iA_VALID, iA_RD, iA_DATA, iB_VALID, iB_RD, iB_DATA,
      output iISSUE, iISSUE_RD, iRS1, iRS2,
      input  oA_READY, oB_READY, oWE, oRD, oWDATA, oHAZARD, oBUSY
   );

   modport slave (
      input  iA_VALID, iA_RD, iA_DATA, iB_VALID, iB_RD, iB_DATA,
      input  iISSUE, iISSUE_RD, iRS1, iRS2,
      output oA_READY, oB_READY, oWE, oRD, oWDATA, oHAZARD, oBUSY
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a pending-destination scoreboard.
// Define REGFILE_WB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin.
module regfile_wb_arbiter #(
   parameter int NREQ = 2
) (
   input logic                 iCLK,
   input logic                 iRST,
   regfile_wb_arbiter_if.slave bus
);
   if (NREQ != 2) begin : gBadNreq
      $error("regfile_wb_arbiter supports only NREQ = 2");
   end

   logic        gntA;
   logic        gntB;
   logic        handshake;
   logic [4:0]  gntRd;
   logic [31:0] gntData;
   logic [31:0] busy;
   logic [31:0] setMask;
   logic [31:0] clrMask;
   logic [31:0] busyNext;
   logic        vld_p1;
   logic [4:0]  rd_p1;
   logic [31:0] wdata_p1;

   // Grants double as READY, so they are gated by reset as well as VALID.
`ifdef REGFILE_WB_FIXED_PRIO_EN
   always_comb begin
      gntA = iRST && bus.iA_VALID;
      gntB = iRST && bus.iB_VALID && !bus.iA_VALID;
   end
`else
   logic prio;

   always_comb begin
      gntA = iRST && bus.iA_VALID && (!bus.iB_VALID || !prio);
      gntB = iRST && bus.iB_VALID && (!bus.iA_VALID || prio);
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)
         prio <= 1'b0;
      else if (handshake)
         prio <= gntA;
   end
`endif

   always_comb begin
      handshake = gntA || gntB;
      gntRd     = gntB ? bus.iB_RD : bus.iA_RD;
      gntData   = gntB ? bus.iB_DATA : bus.iA_DATA;
      setMask   = (bus.iISSUE && (bus.iISSUE_RD != 5'd0)) ? (32'd1 << bus.iISSUE_RD) : 32'd0;
      clrMask   = handshake ? (32'd1 << gntRd) : 32'd0;
      // Set is applied after clear so a same-edge issue keeps the register pending.
      busyNext  = ((busy & ~clrMask) | setMask) & ~32'd1;
   end

   // Stage p1: registered write port and scoreboard
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         vld_p1   <= 1'b0;
         rd_p1    <= 5'd0;
         wdata_p1 <= 32'd0;
         busy     <= 32'd0;
      end else begin
         vld_p1 <= handshake && (gntRd != 5'd0);
         busy   <= busyNext;
         if (handshake && (gntRd != 5'd0)) begin
            rd_p1    <= gntRd;
            wdata_p1 <= gntData;
         end
      end
   end

   assign bus.oA_READY = gntA;
   assign bus.oB_READY = gntB;
   assign bus.oWE      = vld_p1;
   assign bus.oRD      = rd_p1;
   assign bus.oWDATA   = wdata_p1;
   assign bus.oBUSY    = busy;
   assign bus.oHAZARD  = ((bus.iRS1 != 5'd0) && busy[bus.iRS1]) ||
                         ((bus.iRS2 != 5'd0) && busy[bus.iRS2]);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations followed by randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;
   logic iCLK = 1'b0;
   logic iRST = 1'b0;

   regfile_wb_arbiter_if bus();

   regfile_wb_arbiter #(.NREQ(2)) dut (
      .iCLK(iCLK),
      .iRST(iRST),
      .bus (bus)
   );

   always #5 iCLK = ~iCLK;

   int nChk  = 0;
   int nPass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: state that the DUT must hold after the most recent rising edge.
   bit        mPrioB;
   bit [31:0] mBusy;
   bit        mWe;
   bit [4:0]  mRd;
   bit [31:0] mWdata;
   bit        eA, eB, aWins, eHaz;
   bit [4:0]  wRd;
   bit [31:0] wData;

   always @(negedge iCLK) begin
      if (!iRST) begin
         mPrioB = 1'b0; mBusy = '0; mWe = 1'b0; mRd = '0; mWdata = '0;
      end
`ifdef REGFILE_WB_FIXED_PRIO_EN
      aWins = 1'b1;
`else
      aWins = !mPrioB;
`endif
      eA   = iRST && bus.iA_VALID && (!bus.iB_VALID || aWins);
      eB   = iRST && bus.iB_VALID && (!bus.iA_VALID || !aWins);
      eHaz = (bus.iRS1 != 0 && mBusy[bus.iRS1]) || (bus.iRS2 != 0 && mBusy[bus.iRS2]);
      chk("m_readyA", bus.oA_READY, eA);
      chk("m_readyB", bus.oB_READY, eB);
      chk("m_we", bus.oWE, mWe);
      chk("m_rd", bus.oRD, mRd);
      chk("m_wdata", bus.oWDATA, mWdata);
      chk("m_busy", bus.oBUSY, mBusy);
      chk("m_hazard", bus.oHAZARD, eHaz);
      // Advance the model to the state after the coming rising edge.
      if (iRST) begin
         mWe = 1'b0;
         if (eA || eB) begin
            wRd   = eA ? bus.iA_RD : bus.iB_RD;
            wData = eA ? bus.iA_DATA : bus.iB_DATA;
            if (wRd != 0) begin
               mWe = 1'b1; mRd = wRd; mWdata = wData;
            end
            mPrioB = eA;
            mBusy[wRd] = 1'b0;
         end
         if (bus.iISSUE && bus.iISSUE_RD != 0) mBusy[bus.iISSUE_RD] = 1'b1;
         mBusy[0] = 1'b0;
      end
   end

   task automatic idle();
      bus.iA_VALID = 0; bus.iA_RD = 0; bus.iA_DATA = 0;
      bus.iB_VALID = 0; bus.iB_RD = 0; bus.iB_DATA = 0;
      bus.iISSUE = 0; bus.iISSUE_RD = 0;
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

`ifdef REGFILE_WB_FIXED_PRIO_EN
   logic [4:0] exp032 [4] = '{5'd1, 5'd1, 5'd1, 5'd1};
`else
   logic [4:0] exp032 [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
`endif

   initial begin
      idle();
      bus.iRS1 = 0; bus.iRS2 = 0;
      repeat (2) step();
      chk("reset_we", bus.oWE, 0);
      chk("reset_rd", bus.oRD, 0);
      chk("reset_busy", bus.oBUSY, 0);
      chk("reset_ready", {bus.oA_READY, bus.oB_READY}, 0);

      // Single requester A after reset release
      iRST = 1;
      bus.iA_VALID = 1; bus.iA_RD = 5; bus.iA_DATA = 32'h1234;
      #1 chk("a_only_ready", bus.oA_READY, 1);
      step();
      chk("a_only_we", bus.oWE, 1);
      chk("a_only_rd", bus.oRD, 5);
      chk("a_only_wdata", bus.oWDATA, 32'h0000_1234);

      // B alone returns the pointer to A before the contention run
      idle(); bus.iB_VALID = 1; bus.iB_RD = 9; bus.iB_DATA = 32'h99;
      step();
      idle();
      bus.iA_VALID = 1; bus.iA_RD = 1; bus.iA_DATA = 32'hA;
      bus.iB_VALID = 1; bus.iB_RD = 2; bus.iB_DATA = 32'hB;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("contend_we", bus.oWE, 1);
         chk("contend_rd", bus.oRD, exp032[k]);
      end

      // x0 write is accepted but suppressed
      idle(); bus.iA_VALID = 1; bus.iA_RD = 0; bus.iA_DATA = 32'hFFFF_FFFF;
      #1 chk("x0_ready", bus.oA_READY, 1);
      step();
      chk("x0_we", bus.oWE, 0);
      chk("x0_busy", bus.oBUSY, 0);

      // Issue then clear x7 through B
      idle(); bus.iISSUE = 1; bus.iISSUE_RD = 7;
      step();
      idle(); bus.iRS1 = 7;
      #1 chk("haz_set", bus.oHAZARD, 1);
      chk("haz_busy", bus.oBUSY, 32'h80);
      bus.iB_VALID = 1; bus.iB_RD = 7; bus.iB_DATA = 32'h77;
      step();
      chk("haz_clr_busy", bus.oBUSY, 0);
      chk("haz_clr", bus.oHAZARD, 0);

      // Same-edge issue and clear of x3
      idle(); bus.iRS1 = 0; bus.iISSUE = 1; bus.iISSUE_RD = 3;
      step();
      bus.iA_VALID = 1; bus.iA_RD = 3; bus.iA_DATA = 32'h33;
      step();
      chk("setwins_busy", bus.oBUSY, 32'h8);
      chk("setwins_we", bus.oWE, 1);
      chk("setwins_rd", bus.oRD, 3);

      // Build busy = 0xF0, then reset mid-stream
      idle(); bus.iA_VALID = 1; bus.iA_RD = 3; bus.iA_DATA = 32'h3;
      bus.iISSUE = 1; bus.iISSUE_RD = 4;
      step();
      for (int r = 5; r < 8; r++) begin
         idle(); bus.iISSUE = 1; bus.iISSUE_RD = 5'(r);
         step();
      end
      idle();
      chk("pre_rst_busy", bus.oBUSY, 32'hF0);
      chk("rs_zero_haz", bus.oHAZARD, 0);
      bus.iA_VALID = 1; bus.iA_RD = 10; bus.iA_DATA = 32'hAA;
      bus.iB_VALID = 1; bus.iB_RD = 11; bus.iB_DATA = 32'hBB;
      #2 iRST = 0;
      #1 chk("rst_busy", bus.oBUSY, 0);
      chk("rst_we", bus.oWE, 0);
      chk("rst_ready", {bus.oA_READY, bus.oB_READY}, 0);
      step();
      step();
      iRST = 1;
      #1 chk("post_rst_readyA", bus.oA_READY, 1);
      chk("post_rst_readyB", bus.oB_READY, 0);
      chk("post_rst_we", bus.oWE, 0);
      step();
      chk("post_rst_rd", bus.oRD, 10);

      // Randomized traffic, small register range to force collisions
      for (int n = 0; n < 3000; n++) begin
         bus.iA_VALID  = 1'($urandom_range(0, 1));
         bus.iA_RD     = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
         bus.iA_DATA   = $urandom;
         bus.iB_VALID  = 1'($urandom_range(0, 1));
         bus.iB_RD     = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
         bus.iB_DATA   = $urandom;
         bus.iISSUE    = 1'($urandom_range(0, 1));
         bus.iISSUE_RD = 5'($urandom_range(0, 7));
         bus.iRS1      = 5'($urandom_range(0, 8));
         bus.iRS2      = 5'($urandom_range(0, 8));
         iRST          = ($urandom_range(0, 149) != 0);
         step();
      end
      iRST = 1;
      idle();
      step();
      step();
      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, fixed number of writeback requesters (A, B); no other value is supported.
REQ-002 The block SHALL have ports iCLK in 1, rising-edge clock, and iRST in 1, asynchronous active-low reset.
REQ-003 The block SHALL have ports iA_VALID in 1, iA_RD in 5, iA_DATA in 32 and oA_READY out 1, forming requester A's writeback request.
REQ-004 The block SHALL have ports iB_VALID in 1, iB_RD in 5, iB_DATA in 32 and oB_READY out 1, forming requester B's writeback request.
REQ-005 The block SHALL have ports oWE out 1, oRD out 5 and oWDATA out 32, driving the register-file write port.
REQ-006 The block SHALL have ports iISSUE in 1 and iISSUE_RD in 5, marking a destination register as pending.
REQ-007 The block SHALL have ports iRS1 in 5 and iRS2 in 5 (source registers to check) and oHAZARD out 1 (hazard flag).
REQ-008 The block SHALL have port oBUSY out 32, the scoreboard with bit n = xn pending.

Function
REQ-009 A handshake SHALL occur on a requester when its VALID and READY are both 1 at a rising iCLK edge.
REQ-010 READY SHALL be combinational: at most one of oA_READY/oB_READY is 1; READY=0 whenever the matching VALID=0.
REQ-011 Only one valid requester: that requester SHALL be granted.
REQ-012 Both valid: the requester named by 1-bit pointer PRIO (0=A, 1=B) SHALL be granted.
REQ-013 After any handshake, PRIO SHALL point to the non-granted requester; with no handshake, PRIO SHALL hold.
REQ-014 A handshake SHALL produce oWE=1, oRD=granted RD and oWDATA=granted DATA in the following cycle (1-cycle registered latency).
REQ-015 With no handshake, oWE SHALL be 0 next cycle; oRD/oWDATA SHALL hold their last values.
REQ-016 A handshake with RD=0 SHALL be accepted and update PRIO but SHALL produce oWE=0 (x0 writes suppressed).
REQ-017 Back-to-back handshakes SHALL be sustained at one per cycle; no bubble SHALL be inserted.
REQ-018 iISSUE=1 with iISSUE_RD!=0 SHALL set busy[iISSUE_RD] at the clock edge; iISSUE_RD=0 SHALL be ignored.
REQ-019 A handshake SHALL clear busy[granted RD] at the same edge as the handshake.
REQ-020 If issue and clear target the same register at the same edge, busy SHALL end at 1 (set wins).
REQ-021 Clearing an already-clear busy bit SHALL leave it 0, with no error.
REQ-022 busy[0] SHALL be constant 0.
REQ-023 oHAZARD SHALL be combinational: (iRS1!=0 & busy[iRS1]) | (iRS2!=0 & busy[iRS2]), using the registered busy state.
REQ-024 oBUSY SHALL reflect the registered busy vector.

Reset
REQ-025 iRST=0 SHALL immediately force oWE=0, oRD=0, oWDATA=0, busy=0 and PRIO=0 (A), independent of iCLK.
REQ-026 While iRST=0, oA_READY and oB_READY SHALL be 0 and no handshake SHALL occur.
REQ-027 A handshake pending when reset asserts SHALL be dropped; its oWE SHALL not appear after release.
REQ-028 Normal operation SHALL resume at the first rising iCLK edge after iRST returns to 1.

Configuration
REQ-029 Macro REGFILE_WB_FIXED_PRIO_EN defined: A SHALL always win when both requesters are valid, and PRIO SHALL be unused.
REQ-030 Macro REGFILE_WB_FIXED_PRIO_EN undefined: arbitration SHALL be round-robin per REQ-012/013.

Verification
REQ-031 Reset release, then A valid (rd=5, 0x1234) only -> oA_READY=1; next cycle oWE=1, oRD=5, oWDATA=0x00001234.
REQ-032 A (rd=1, 0xA) and B (rd=2, 0xB) held valid 4 cycles -> grants A,B,A,B; oRD sequence 1,2,1,2 (with macro: A,A,A,A).
REQ-033 A valid, rd=0, data 0xFFFFFFFF -> handshake occurs; next cycle oWE=0; busy unchanged.
REQ-034 Issue rd=7, then iRS1=7 -> oHAZARD=1; B handshake rd=7 -> busy[7]=0 after edge and oHAZARD=0; iRS2=0 never flags.
REQ-035 Same edge: issue rd=3 and A handshake rd=3 while busy[3]=1 -> busy[3] remains 1; oWE=1, oRD=3 next cycle.
REQ-036 iRST=0 asserted mid-stream with busy=0x000000F0 -> oBUSY=0 and oWE=0 immediately; after release PRIO=A.
